// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with a valid/ready handshake and
// a two-entry skid buffer. It also supports synchronous flush and counts
// stall cycles.
//
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   flush       - discard held beats and any beat accepted this cycle
//   in_valid    - upstream handshake valid
//   in_ready    - upstream handshake ready (registered)
//   in_data     - upstream payload
//   out_valid   - downstream handshake valid (registered)
//   out_ready   - downstream handshake ready
//   out_data    - downstream payload (registered)
//   occupancy   - number of held beats: 0, 1 or 2 (registered)
//   stall_cnt   - saturating count of cycles with out_valid & !out_ready
//
// All handshake outputs come directly from flops. No combinational path
// exists from out_ready to in_ready.
module pipe_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_nxt;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = main_q;

  // State register plus registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      state_q   <= state_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
      occupancy <= 2'(state_nxt);
    end
  end

  // Next-state and data-load decisions.
  always_comb begin
    state_nxt      = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Payload storage: the main entry drives out_data, and skid holds the overflow beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  // Saturating stall counter. Flush does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a stall-cycle counter. It generalises our hand-written IF/ID, ID/EX, EX/MEM and MEM/WB latches so that the next-generation datapath can stall, flush and insert bubbles per stage without ad-hoc enables. Every control path is registered, so no combinational path runs from downstream `out_ready` back to upstream `in_ready`. This lets stages be chained without long timing paths.

## Interface
Parameters:
- DATA_W, 32, width of the bundled stage payload (packed control + data fields)
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  discard all held and incoming beats this cycle
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat; registered
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  beat presented downstream; registered
- out_ready  in  1  downstream accepts beat
- out_data  out  DATA_W  downstream payload; registered
- occupancy  out  2  number of held beats: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Beat transfer rules:
  - Input fire (in_fire) = in_valid & in_ready.
  - Output fire (out_fire) = out_valid & out_ready.
- Storage: a main entry (drives out_data) and a skid entry.
- States: EMPTY (occ 0), ONE (main valid), FULL (main + skid valid).
- Outputs per state:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
- Transitions, when not flushing:
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data.
  - ONE: in_fire only -> FULL, skid <= in_data.
  - ONE: out_fire only -> EMPTY.
  - ONE: neither -> hold.
  - FULL: out_fire -> ONE, main <= skid. in_fire cannot occur in FULL.
  - FULL: otherwise -> hold.
- Ordering: beats leave in arrival order. No beat is duplicated or dropped except by flush.
- Flush:
  - Next state is EMPTY, whatever the handshake.
  - A beat accepted in the flush cycle is discarded.
  - A beat fired downstream in the flush cycle is considered delivered.
  - Data registers are not cleared; out_data is meaningful only while out_valid=1.
- Reset: has priority over flush.
  - State EMPTY.
  - main and skid data = 0.
  - stall_cnt = 0.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset; flush does not clear it.
- occupancy reflects the registered state (0/1/2).

## Timing
- Reset values:
  - out_valid=0, out_data=0.
  - in_ready=1.
  - occupancy=0, stall_cnt=0.
  - All take effect in the cycle after reset is sampled high.
- Latency: a beat accepted at edge N, with the stage EMPTY or draining, appears on out_data/out_valid after edge N.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Back-pressure: when out_ready drops with the stage in ONE, one more beat can be accepted (into skid). in_ready falls the cycle after that beat is accepted.
- in_ready rises in the cycle after out_fire from FULL.
- Flush: out_valid=0 and in_ready=1 in the cycle after flush is sampled high.
- Reset mid-operation: all held beats are lost; behaviour matches the flush case plus counter clear.

## Test plan
- Reset then stream: assert reset for 2 cycles, then send 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1. Required: out_data shows 0x11, 0x22, 0x33 on the 3 cycles after each accept; occupancy stays at 1; stall_cnt=0.
- Skid fill: while in ONE holding 0xA1, drop out_ready and present 0xA2. Required: 0xA2 accepted, occupancy=2, in_ready=0 next cycle. Then raise out_ready. Required: 0xA1 delivered, then 0xA2; in_ready=1 in the cycle after the first out_fire.
- Stall counting: hold out_valid=1 with out_ready=0 for 5 cycles. Required: stall_cnt=5. With CNT_W=3, hold for 10 cycles. Required: stall_cnt saturates at 7.
- Flush in FULL: flush with 2 beats held while in_valid=1 presents 0x55. Required: next cycle out_valid=0, occupancy=0; 0x55 never appears at the output; stall_cnt unchanged.
- Flush with simultaneous out_fire: flush while ONE, out_ready=1 and in_valid=1. Required: held beat delivered that cycle, incoming beat dropped, state EMPTY.
- Reset beats flush: reset=1 and flush=1 together while FULL with stall_cnt=4. Required: occupancy=0, out_data=0, stall_cnt=0.
